// File: rtl/booth_mult_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states and
// the partial-product recode selector.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } recode_t;

    // {L[1], L[0], q} -> partial-product selection
    function automatic recode_t booth_recode(input logic [2:0] bits);
        recode_t r;
        case (bits)
            3'b001, 3'b010: r = POS1;
            3'b011:         r = POS2;
            3'b100:         r = NEG2;
            3'b101, 3'b110: r = NEG1;
            default:        r = ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Booth partial-product select: picks 0/+M/+2M/-M/-2M; negation is ~X with cin=1.
module booth_pp_sel
    import booth_mult_pkg::*;
#(
    parameter int HW = 16
) (
    input  logic [2:0]    bits,
    input  logic [HW-1:0] m,
    output logic [HW-1:0] opnd,
    output logic          cin
);

    always_comb begin
        opnd = '0;
        cin  = 1'b0;
        case (booth_recode(bits))
            POS1: opnd = m;
            POS2: opnd = {m[HW-2:0], 1'b0};
            NEG1: begin
                opnd = ~m;
                cin  = 1'b1;
            end
            NEG2: begin
                opnd = ~{m[HW-2:0], 1'b0};
                cin  = 1'b1;
            end
            default: opnd = '0;
        endcase
    end

endmodule

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice; slices are chained by rippling cout into cin.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH, valid/ready on both sides.
// Define BOOTH_SEQ_EARLY_TERM_EN to finish early once the remaining multiplier bits are all 0 or all 1.
module booth_seq_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int HW   = WIDTH + 4;
    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER + 1);
    localparam int NIB  = HW / 4;

    state_t          state;
    logic [HW-1:0]   m;
    logic [HW-1:0]   h;
    logic [WIDTH-1:0] l;
    logic            q;
    logic [CW-1:0]   k;

    logic [HW-1:0]   opnd;
    logic [HW-1:0]   hp;
    logic            cin;
    logic [NIB-1:0]  c;
    logic            cout_unused;

    booth_pp_sel #(.HW(HW)) u_pp_sel (
        .bits (l[1:0] == 2'b00 && !q ? 3'b000 : {l[1:0], q}),
        .m    (m),
        .opnd (opnd),
        .cin  (cin)
    );

    assign c[0] = cin;

    for (genvar i = 0; i < NIB; i++) begin : g_add
        if (i < NIB - 1) begin : g_mid
            cla_4bit u_cla (
                .a    (h[4*i+3:4*i]),
                .b    (opnd[4*i+3:4*i]),
                .cin  (c[i]),
                .s    (hp[4*i+3:4*i]),
                .cout (c[i+1])
            );
        end else begin : g_top
            cla_4bit u_cla (
                .a    (h[4*i+3:4*i]),
                .b    (opnd[4*i+3:4*i]),
                .cin  (c[i]),
                .s    (hp[4*i+3:4*i]),
                .cout (cout_unused)
            );
        end
    end

    // {H', L, q} arithmetic shift right by 2
    logic [HW-1:0]      h_nx;
    logic [WIDTH-1:0]   l_nx;
    logic               q_nx;
    logic [HW-1:0]      h_fin;
    logic [WIDTH-1:0]   l_fin;
    logic [2*WIDTH-1:0] p_fin;
    logic               last;

    assign h_nx = {{2{hp[HW-1]}}, hp[HW-1:2]};
    assign l_nx = {hp[1:0], l[WIDTH-1:2]};
    assign q_nx = l[1];

`ifdef BOOTH_SEQ_EARLY_TERM_EN
    localparam int SW = CW + 1;

    logic [SW-1:0]                et_sh;
    logic [WIDTH-1:0]             et_mask;
    logic [WIDTH-1:0]             l_rem;
    logic signed [HW+WIDTH-1:0]   et_cat;

    // After this iteration, the unconsumed bits are l_nx[et_sh-1:0] plus q_nx
    assign et_sh   = (SW'(ITER - 1) - SW'(k)) << 1;
    assign et_mask = ~({WIDTH{1'b1}} << et_sh);
    assign l_rem   = l_nx & et_mask;
    assign last    = q_nx ? (l_rem == et_mask) : (l_rem == '0);
    assign et_cat  = $signed({h_nx, l_nx}) >>> et_sh;
    assign h_fin   = last ? et_cat[HW+WIDTH-1:WIDTH] : h_nx;
    assign l_fin   = last ? et_cat[WIDTH-1:0] : l_nx;
    assign p_fin   = et_cat[2*WIDTH-1:0];
`else
    assign last  = (k == CW'(ITER - 1));
    assign h_fin = h_nx;
    assign l_fin = l_nx;
    assign p_fin = {h_nx[WIDTH-1:0], l_nx};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= '0;
            m         <= '0;
            h         <= '0;
            l         <= '0;
            q         <= 1'b0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m        <= {{4{in_a[WIDTH-1]}}, in_a};
                        h        <= '0;
                        l        <= in_b;
                        q        <= 1'b0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    h <= h_fin;
                    l <= l_fin;
                    q <= q_nx;
                    k <= k + CW'(1);
                    if (last) begin
                        out_p     <= p_fin;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
